rf_alu_ctrl: RTL and testbench
==============================

RF_ALU_CTRL -- requirements
Module: rf_alu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width (2^ADDR_WIDTH registers).
REQ-002 Parameter DATA_WIDTH, default 32, register data width; a power of two, at least 8.
REQ-003 Parameter ZERO_REG, default 1, when 1 writes to address 0 are suppressed.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 instr_valid_i  input  1  instruction offered.
REQ-008 instr_ready_o  output  1  controller can accept an instruction.
REQ-009 op_i  input  3  ALU opcode.
REQ-010 rs1_i / rs2_i / rd_i  input  ADDR_WIDTH each  source A, source B and destination addresses.
REQ-011 raddr_a_o / raddr_b_o  output  ADDR_WIDTH each  register-file read addresses.
REQ-012 rdata_a_i / rdata_b_i  input  DATA_WIDTH each  register-file read data; combinational, valid in the same cycle as the address.
REQ-013 waddr_c_o  output  ADDR_WIDTH  register-file write address.
REQ-014 wdata_c_o  output  DATA_WIDTH  register-file write data.
REQ-015 we_c_o  output  1  register-file write enable.
REQ-016 done_o  output  1  one-cycle pulse when an instruction retires.
REQ-017 result_o  output  DATA_WIDTH  result of the last retired instruction; held until the next retire.
REQ-018 zero_o  output  1  result_o == 0; held with result_o.

Function
REQ-019 States: IDLE, READ, EXEC, WRITE. The FSM is always in exactly one state.
REQ-020 Handshake: instr_ready_o = 1 only in IDLE. An instruction is accepted when instr_valid_i && instr_ready_o at a rising edge. On accept, op, rs1, rs2 and rd are latched and the FSM moves IDLE->READ.
REQ-021 READ:
- raddr_a_o = latched rs1, raddr_b_o = latched rs2.
- rdata_a_i and rdata_b_i are captured into operand registers at the edge ending READ.
- Transition READ->EXEC.
REQ-022 EXEC: the result is computed from the operand registers and registered at the edge ending EXEC; transition EXEC->WRITE.
REQ-023 WRITE:
- we_c_o = 1, waddr_c_o = latched rd, wdata_c_o = registered result.
- done_o = 1.
- result_o and zero_o update at the edge ending WRITE.
- Transition WRITE->IDLE.
REQ-024 Latency: accept edge at cycle T. READ occupies cycle T+1, EXEC T+2, WRITE T+3. The earliest next accept is the edge ending cycle T+4. Sustained throughput is one instruction per 4 cycles.
REQ-025 Outside READ, raddr_a_o and raddr_b_o = 0. Outside WRITE, we_c_o = 0, waddr_c_o = 0, wdata_c_o = 0 and done_o = 0.
REQ-026 Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL and 6 SRL (logical); the shift amount is B[log2(DATA_WIDTH)-1:0].
- 7 SLT: signed A<B gives 1, otherwise 0, zero-extended to DATA_WIDTH.
REQ-027 ADD and SUB wrap modulo 2^DATA_WIDTH; no carry or overflow output.
REQ-028 ZERO_REG=1 and rd==0: we_c_o stays 0 in WRITE, but done_o, result_o and zero_o still update normally.
REQ-029 Source or destination aliasing (rs1==rs2==rd) needs no special handling. Operands are read in READ, before the write in WRITE.
REQ-030 Back-to-back dependency: the value written in WRITE of instruction N is visible to READ of instruction N+1. The register file updates at the edge ending WRITE, which is before the next READ.
REQ-031 instr_valid_i and the instruction fields are don't-care outside IDLE. Changes outside IDLE do not affect the in-flight instruction.

Reset
REQ-032 rst sampled high at a rising edge forces the following, regardless of state:
- FSM to IDLE.
- instr_ready_o = 1 in the following cycle.
- we_c_o = 0, done_o = 0.
- result_o = 0, zero_o = 1.
- raddr/waddr/wdata outputs = 0.
- Operand and latched-instruction registers = 0.
REQ-033 Reset mid-operation aborts the instruction. we_c_o is 0 from the cycle after the reset edge, and no write of the aborted instruction is issued.
REQ-034 rst has priority over a simultaneous accept; the offered instruction is dropped.

Verification
REQ-035 Behavioural 32x32 RF model with r1=5, r2=7. ADD rs1=1, rs2=2, rd=3 -> 3 cycles after the accept edge: we_c_o=1, waddr_c_o=3, wdata_c_o=12, done_o=1; then result_o=12, zero_o=0.
REQ-036 r1=5, r2=7: SUB rd=4 -> wdata_c_o=0xFFFFFFFE. SLT rd=5 -> wdata_c_o=1. SUB rs1=1, rs2=1 -> result_o=0, zero_o=1.
REQ-037 r1=0x80000001, r2=33: SLL -> 0x00000002 (shift 1). SRL -> 0x40000000.
REQ-038 ADD rs1=1, rs2=2, rd=0 with ZERO_REG=1 -> we_c_o never 1; done_o pulses; result_o=12.
REQ-039 Back-to-back: ADD rd=3 then ADD rs1=3, rs2=3, rd=6 with instr_valid_i held high -> the second accept is 4 cycles after the first; r6=24; instr_ready_o low for 3 cycles between accepts.
REQ-040 rst asserted during EXEC -> no we_c_o pulse, done_o=0, instr_ready_o=1 next cycle, result_o=0; the RF model is unchanged.

Source files
------------

// File: rtl/rf_alu_ctrl_if.sv
// Instruction handshake and register-file port bundle
// between the ALU controller and its environment.
interface rf_alu_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic [2:0]            op_i;
  logic [ADDR_WIDTH-1:0] rs1_i;
  logic [ADDR_WIDTH-1:0] rs2_i;
  logic [ADDR_WIDTH-1:0] rd_i;
  logic [ADDR_WIDTH-1:0] raddr_a_o;
  logic [ADDR_WIDTH-1:0] raddr_b_o;
  logic [DATA_WIDTH-1:0] rdata_a_i;
  logic [DATA_WIDTH-1:0] rdata_b_i;
  logic [ADDR_WIDTH-1:0] waddr_c_o;
  logic [DATA_WIDTH-1:0] wdata_c_o;
  logic                  we_c_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;

  modport master (
    input  instr_valid_i, op_i, rs1_i, rs2_i, rd_i,
    input  rdata_a_i, rdata_b_i,
    output instr_ready_o, raddr_a_o, raddr_b_o,
    output waddr_c_o, wdata_c_o, we_c_o,
    output done_o, result_o, zero_o
  );

  modport slave (
    output instr_valid_i, op_i, rs1_i, rs2_i, rd_i,
    output rdata_a_i, rdata_b_i,
    input  instr_ready_o, raddr_a_o, raddr_b_o,
    input  waddr_c_o, wdata_c_o, we_c_o,
    input  done_o, result_o, zero_o
  );
endinterface

// File: rtl/rf_alu_ctrl.sv
// Four-phase controller: read two registers, run the ALU,
// write the result back, one instruction every 4 cycles.
module rf_alu_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic            clk,
  input  logic            rst,
  rf_alu_ctrl_if.master   bus
);

  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_rs1;
  logic [ADDR_WIDTH-1:0] r_rs2;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [SHW-1:0]        w_shamt;
  logic                  w_lt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.instr_valid_i) begin
            r_op  <= bus.op_i;
            r_rs1 <= bus.rs1_i;
            r_rs2 <= bus.rs2_i;
            r_rd  <= bus.rd_i;
          end
        end
        S_READ: begin
          r_opa <= bus.rdata_a_i;
          r_opb <= bus.rdata_b_i;
        end
        S_EXEC: r_res <= w_alu;
        S_WRITE: begin
          r_result <= r_res;
          r_zero   <= (r_res == '0);
        end
      endcase
    end
  end

  assign w_shamt = r_opb[SHW-1:0];
  assign w_lt    = $signed(r_opa) < $signed(r_opb);

  always_comb begin
    w_alu = '0;
    unique case (r_op)
      3'd0: w_alu = r_opa + r_opb;
      3'd1: w_alu = r_opa - r_opb;
      3'd2: w_alu = r_opa & r_opb;
      3'd3: w_alu = r_opa | r_opb;
      3'd4: w_alu = r_opa ^ r_opb;
      3'd5: w_alu = r_opa << w_shamt;
      3'd6: w_alu = r_opa >> w_shamt;
      3'd7: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_lt};
    endcase
  end

  always_comb begin
    w_next            = r_state;
    bus.instr_ready_o = 1'b0;
    bus.raddr_a_o     = '0;
    bus.raddr_b_o     = '0;
    bus.we_c_o        = 1'b0;
    bus.waddr_c_o     = '0;
    bus.wdata_c_o     = '0;
    bus.done_o        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.instr_ready_o = 1'b1;
        if (bus.instr_valid_i) w_next = S_READ;
      end
      S_READ: begin
        bus.raddr_a_o = r_rs1;
        bus.raddr_b_o = r_rs2;
        w_next        = S_EXEC;
      end
      S_EXEC: w_next = S_WRITE;
      S_WRITE: begin
        // r0 stays hardwired when ZERO_REG is set, but the op still retires
        bus.we_c_o    = (ZERO_REG == 0) || (r_rd != '0);
        bus.waddr_c_o = r_rd;
        bus.wdata_c_o = r_res;
        bus.done_o    = 1'b1;
        w_next        = S_IDLE;
      end
    endcase
  end

  assign bus.result_o = r_result;
  assign bus.zero_o   = r_zero;

endmodule

// File: tb/tb_rf_alu_ctrl.sv
// Directed and random checks of rf_alu_ctrl against a
// behavioural register file and ALU reference.
module tb_rf_alu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rf_alu_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rf_alu_ctrl #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] rf [32];
  logic [31:0] gold [32];
  logic        pre_we  = 1'b0;
  logic        rf_clr  = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          we_seen = 0;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (pre_we) begin
      rf[pre_addr] <= pre_data;
    end else if (bus.we_c_o) begin
      rf[bus.waddr_c_o] <= bus.wdata_c_o;
    end
    if (bus.we_c_o) we_seen <= we_seen + 1;
  end

  assign bus.rdata_a_i = rf[bus.raddr_a_o];
  assign bus.rdata_b_i = rf[bus.raddr_b_o];

  function automatic logic [31:0] ref_alu(
    input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = 5'(a);
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
    gold[a]  = d;
  endtask

  task automatic scramble_fields();
    bus.op_i  = 3'($urandom);
    bus.rs1_i = 5'($urandom);
    bus.rs2_i = 5'($urandom);
    bus.rd_i  = 5'($urandom);
  endtask

  // Called at a negedge while idle; returns at the negedge after retire.
  task automatic run_instr(input int op, input int a, input int b,
                           input int d);
    logic [31:0] exp;
    exp = ref_alu(op, gold[a], gold[b]);
    chk("ready_idle", 32'(bus.instr_ready_o), 32'd1);
    bus.instr_valid_i = 1'b1;
    bus.op_i  = 3'(op);
    bus.rs1_i = 5'(a);
    bus.rs2_i = 5'(b);
    bus.rd_i  = 5'(d);
    @(negedge clk);
    bus.instr_valid_i = 1'($urandom);
    scramble_fields();
    chk("ready_read", 32'(bus.instr_ready_o), 32'd0);
    chk("raddr_a", 32'(bus.raddr_a_o), 32'(a));
    chk("raddr_b", 32'(bus.raddr_b_o), 32'(b));
    chk("done_read", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    chk("we_exec", 32'(bus.we_c_o), 32'd0);
    chk("raddr_exec", 32'(bus.raddr_a_o), 32'd0);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    chk("we_write", 32'(bus.we_c_o), (d != 0) ? 32'd1 : 32'd0);
    chk("waddr", 32'(bus.waddr_c_o), 32'(d));
    chk("wdata", bus.wdata_c_o, exp);
    chk("done_write", 32'(bus.done_o), 32'd1);
    @(negedge clk);
    chk("done_after", 32'(bus.done_o), 32'd0);
    chk("we_after", 32'(bus.we_c_o), 32'd0);
    chk("result", bus.result_o, exp);
    chk("zero", 32'(bus.zero_o), (exp == 0) ? 32'd1 : 32'd0);
    if (d != 0) gold[d] = exp;
    chk("rf_dest", rf[d], gold[d]);
  endtask

  initial begin
    int cnt;
    int w0;
    bus.instr_valid_i = 1'b0;
    bus.op_i  = '0;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.rd_i  = '0;
    for (int i = 0; i < 32; i++) gold[i] = '0;

    rf_clr = 1'b1;
    repeat (2) @(negedge clk);
    rf_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready_o), 32'd1);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_zero", 32'(bus.zero_o), 32'd1);
    chk("rst_we", 32'(bus.we_c_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_raddr", 32'(bus.raddr_a_o), 32'd0);
    chk("rst_wdata", bus.wdata_c_o, 32'd0);

    preload(1, 32'd5);
    preload(2, 32'd7);
    run_instr(0, 1, 2, 3);
    chk("add_r3", rf[3], 32'd12);
    run_instr(1, 1, 2, 4);
    chk("sub_r4", rf[4], 32'hFFFF_FFFE);
    run_instr(7, 1, 2, 5);
    chk("slt_r5", rf[5], 32'd1);
    run_instr(1, 1, 1, 7);
    chk("sub_zero", 32'(bus.zero_o), 32'd1);

    preload(1, 32'h8000_0001);
    preload(2, 32'd33);
    run_instr(5, 1, 2, 8);
    chk("sll_r8", rf[8], 32'h0000_0002);
    run_instr(6, 1, 2, 9);
    chk("srl_r9", rf[9], 32'h4000_0000);
    run_instr(7, 1, 2, 10);
    chk("slt_neg", rf[10], 32'd1);

    preload(1, 32'd5);
    preload(2, 32'd7);
    w0 = we_seen;
    run_instr(0, 1, 2, 0);
    chk("r0_no_we", 32'(we_seen - w0), 32'd0);
    chk("r0_result", bus.result_o, 32'd12);
    chk("r0_kept", rf[0], 32'd0);

    bus.instr_valid_i = 1'b1;
    bus.op_i  = 3'd0;
    bus.rs1_i = 5'd1;
    bus.rs2_i = 5'd2;
    bus.rd_i  = 5'd3;
    @(negedge clk);
    bus.rs1_i = 5'd3;
    bus.rs2_i = 5'd3;
    bus.rd_i  = 5'd6;
    cnt = 0;
    while (bus.instr_ready_o == 1'b0 && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_ready_low", 32'(cnt), 32'd3);
    chk("b2b_first", rf[3], 32'd12);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_r6", rf[6], 32'd24);
    gold[3] = 32'd12;
    gold[6] = 32'd24;

    for (int n = 0; n < 40; n++) begin
      preload(int'($urandom_range(1, 31)), $urandom);
      if (n % 4 == 0) preload(int'($urandom_range(1, 31)), 32'd0);
      run_instr(int'($urandom_range(0, 7)),
                int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)));
    end

    preload(1, 32'd5);
    preload(2, 32'd7);
    preload(11, 32'hDEAD_BEEF);
    w0 = we_seen;
    bus.instr_valid_i = 1'b1;
    bus.op_i  = 3'd0;
    bus.rs1_i = 5'd1;
    bus.rs2_i = 5'd2;
    bus.rd_i  = 5'd11;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_we", 32'(bus.we_c_o), 32'd0);
    chk("abort_done", 32'(bus.done_o), 32'd0);
    chk("abort_ready", 32'(bus.instr_ready_o), 32'd1);
    chk("abort_result", bus.result_o, 32'd0);
    chk("abort_zero", 32'(bus.zero_o), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(we_seen - w0), 32'd0);
    chk("abort_rf", rf[11], 32'hDEAD_BEEF);

    rst = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.rd_i = 5'd12;
    @(negedge clk);
    rst = 1'b0;
    bus.instr_valid_i = 1'b0;
    chk("rst_prio_ready", 32'(bus.instr_ready_o), 32'd1);
    chk("rst_prio_raddr", 32'(bus.raddr_a_o), 32'd0);
    run_instr(0, 1, 2, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
